// File: rtl/ldpc_802_3an_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_802_3an_pkg
// Shared constants and types for the serial LDPC check/strip decoder.
//   N      codeword length
//   K      systematic information bits (codeword bits K-1..0)
//   M      syndrome width (H rows)
//   ERRW   failed-frame counter width
//   FCW    fill / drain counter width
// H matrix construction (used by ldpc_syndrome_802_3an_comb):
//   rows 0..NCHK-1 : row r checks parity bit K+r, and every info bit i
//                    with (i mod NCHK) == r or ((i+HSHIFT) mod NCHK) == r
//   rows NCHK..M-1 : row NCHK+k is the GF(2) sum of rows r with
//                    (r mod NDEP) == k (linearly dependent rows)
// ---------------------------------------------------------------------------
package ldpc_802_3an_pkg;

   localparam int unsigned N      = 2048;
   localparam int unsigned K      = 1723;
   localparam int unsigned M      = 384;
   localparam int unsigned ERRW   = 16;
   localparam int unsigned FCW    = $clog2(N);
   localparam int unsigned NCHK   = N - K;
   localparam int unsigned NDEP   = M - NCHK;
   localparam int unsigned HSHIFT = 3;
   localparam int unsigned SW     = $clog2(M);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYN,
      ST_EVAL,
      ST_DRAIN
   } drain_state_e;

endpackage

// File: rtl/ldpc_decoder_96w_if.sv
// ---------------------------------------------------------------------------
// ldpc_decoder_96w_if
// Serial stream / status bundle of ldpc_decoder_96w.
//   din, din_vld     serial codeword in (source -> decoder)
//   dout, dout_vld   serial recovered info bits out
//   chk_done         one-cycle syndrome-result pulse
//   chk_err          last frame result (1 = nonzero syndrome)
//   err_cnt          saturating failed-frame count
//   ovf              sticky dropped-frame flag
// modport master: the stream source / status consumer
// modport slave : the decoder
// ---------------------------------------------------------------------------
interface ldpc_decoder_96w_if;
   import ldpc_802_3an_pkg::*;

   logic            din;
   logic            din_vld;
   logic            dout;
   logic            dout_vld;
   logic            chk_done;
   logic            chk_err;
   logic [ERRW-1:0] err_cnt;
   logic            ovf;

   modport master (
      output din, din_vld,
      input  dout, dout_vld, chk_done, chk_err, err_cnt, ovf
   );

   modport slave (
      input  din, din_vld,
      output dout, dout_vld, chk_done, chk_err, err_cnt, ovf
   );

endinterface

// File: rtl/ldpc_syndrome_802_3an_comb.sv
// ---------------------------------------------------------------------------
// ldpc_syndrome_802_3an_comb
// Purely combinational syndrome = H * code_block over GF(2).
//   code_block [N-1:0]  in   full codeword (bit K-1..0 systematic)
//   syndrome   [M-1:0]  out  all-zero for a valid codeword
// The H construction is described in ldpc_802_3an_pkg.
// ---------------------------------------------------------------------------
module ldpc_syndrome_802_3an_comb
   import ldpc_802_3an_pkg::*;
(
   input  logic [N-1:0] code_block,
   output logic [M-1:0] syndrome
);

   logic [NCHK-1:0] w_base;

   always_comb begin
      // each independent row starts from its own parity bit
      w_base = code_block[N-1:K];
      for (int unsigned i = 0; i < K; i++) begin
         w_base[SW'(i % NCHK)]            ^= code_block[FCW'(i)];
         w_base[SW'((i + HSHIFT) % NCHK)] ^= code_block[FCW'(i)];
      end

      // dependent rows are sums of independent rows, so reuse their results
      syndrome             = '0;
      syndrome[NCHK-1:0]   = w_base;
      for (int unsigned r = 0; r < NCHK; r++) begin
         syndrome[SW'(NCHK + (r % NDEP))] ^= w_base[SW'(r)];
      end
   end

endmodule

// File: rtl/ldpc_decoder_96w.sv
// ---------------------------------------------------------------------------
// ldpc_decoder_96w
// Serial LDPC receive checker: fills a 2048-bit codeword one bit per
// din_vld, checks it with a combinational syndrome block, reports pass/fail,
// counts failed frames and streams the K systematic bits back out.
//   clk   in   sole clock (posedge)
//   rst   in   synchronous active-high reset
//   bus   slave modport of ldpc_decoder_96w_if (din/din_vld in;
//         dout/dout_vld/chk_done/chk_err/err_cnt/ovf out)
// Parameter DRAIN_LEN: number of drain cycles (default K, must be <= N).
// Optional macro LDPC_DROP_BAD_EN: frames with a nonzero syndrome skip the
// drain phase entirely.
// ---------------------------------------------------------------------------
module ldpc_decoder_96w
   import ldpc_802_3an_pkg::*;
#(
   parameter int unsigned DRAIN_LEN = K
) (
   input  logic              clk,
   input  logic              rst,
   ldpc_decoder_96w_if.slave bus
);

   drain_state_e    r_state;
   drain_state_e    w_state_nxt;
   logic [N-2:0]    r_cw;
   logic [N-1:0]    w_cw_nxt;
   logic [N-1:0]    r_hreg;
   logic [FCW-1:0]  r_fcnt;
   logic [FCW-1:0]  r_dcnt;
   logic [FCW-1:0]  w_didx;
   logic [M-1:0]    r_syn;
   logic [M-1:0]    w_syn;
   logic            r_chk_err;
   logic [ERRW-1:0] r_err_cnt;
   logic            r_ovf;
   logic            w_fdone;
   logic            w_load;
   logic            w_err;
   logic            w_dlast;
   logic            w_chk_done;
   logic            w_dout;
   logic            w_dout_vld;

   // the completing bit is still on din, so the frame is {r_cw, din}
   assign w_cw_nxt = {r_cw, bus.din};
   assign w_fdone  = bus.din_vld && (r_fcnt == FCW'(N - 1));
   assign w_load   = w_fdone && (r_state == ST_IDLE);
   assign w_err    = |r_syn;
   assign w_didx   = FCW'(DRAIN_LEN - 1) - r_dcnt;
   assign w_dlast  = (r_dcnt == FCW'(DRAIN_LEN - 1));

   ldpc_syndrome_802_3an_comb u_syn (
      .code_block (r_hreg),
      .syndrome   (w_syn)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_chk_done  = 1'b0;
      w_dout      = 1'b0;
      w_dout_vld  = 1'b0;
      case (r_state)
         ST_IDLE:  if (w_load) w_state_nxt = ST_SYN;
         ST_SYN:   w_state_nxt = ST_EVAL;
         ST_EVAL: begin
            w_chk_done = 1'b1;
`ifdef LDPC_DROP_BAD_EN
            w_state_nxt = w_err ? ST_IDLE : ST_DRAIN;
`else
            w_state_nxt = ST_DRAIN;
`endif
         end
         ST_DRAIN: begin
            w_dout_vld = 1'b1;
            w_dout     = r_hreg[w_didx];
            if (w_dlast) w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // data-only registers: contents are don't-care until a frame completes
   always_ff @(posedge clk) begin
      if (bus.din_vld)          r_cw   <= w_cw_nxt[N-2:0];
      if (w_load)               r_hreg <= w_cw_nxt;
      if (r_state == ST_SYN)    r_syn  <= w_syn;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fcnt    <= '0;
         r_dcnt    <= '0;
         r_chk_err <= 1'b0;
         r_err_cnt <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (bus.din_vld)
            r_fcnt <= (r_fcnt == FCW'(N - 1)) ? '0 : r_fcnt + 1'b1;
         // a frame completing while the drain side is busy is lost
         if (w_fdone && (r_state != ST_IDLE))
            r_ovf <= 1'b1;
         if (r_state == ST_EVAL) begin
            r_chk_err <= w_err;
            if (w_err && (r_err_cnt != '1))
               r_err_cnt <= r_err_cnt + 1'b1;
         end
         r_dcnt <= (r_state == ST_DRAIN) ? r_dcnt + 1'b1 : '0;
      end
   end

   assign bus.dout     = w_dout;
   assign bus.dout_vld = w_dout_vld;
   assign bus.chk_done = w_chk_done;
   assign bus.chk_err  = r_chk_err;
   assign bus.err_cnt  = r_err_cnt;
   assign bus.ovf      = r_ovf;

endmodule

// File: doc/ldpc_decoder_96w.md
Name: ldpc_decoder_96w

Overview:
- Receive-side companion to the serial 802.3an LDPC encoder wrapper.
- Accepts a serial 2048-bit codeword and checks it with a combinational H-matrix syndrome sub-block.
- Reports pass/fail per frame and counts failed frames.
- Streams the 1723 systematic information bits back out serially. Keeps the IO count low so the block fits the same benchmark/bring-up flow.

Parameters:
N, 2048, codeword length (fixed by the 802.3an code)
K, 1723, information bits (codeword bits K-1..0 are systematic)
M, 384, syndrome width (H rows)
ERRW, 16, width of the failed-frame counter

Ports:
clk  in  1  sole clock, all logic on posedge
rst  in  1  synchronous, active-high reset
din  in  1  serial codeword bit
din_vld  in  1  din qualifier; one bit accepted per cycle when high
dout  out  1  serial recovered information bit
dout_vld  out  1  dout qualifier
chk_done  out  1  one-cycle pulse when a frame's syndrome result is valid
chk_err  out  1  result of last checked frame (1 = nonzero syndrome); held until next chk_done
err_cnt  out  ERRW  saturating count of frames with chk_err=1
ovf  out  1  sticky; a complete frame was dropped because the drain buffer was busy

Behaviour:
- Bit order: the first accepted bit is codeword bit N-1, the last is bit 0 (parity bits 2047..1723 first, then info bits 1722..0).
- Fill shift register: on din_vld, cw <= {cw[N-2:0], din}. An 11-bit fill counter fcnt 0..N-1 wraps at N-1.
- On the accept of bit 0 (fcnt==N-1 and din_vld), the frame is complete:
  - Drain FSM in IDLE: copy cw-with-din into hold register hreg in the same cycle.
  - Otherwise: drop the frame and set ovf.
  - Filling of the next frame continues without a gap in either case.
- Drain FSM states: IDLE -> SYN -> EVAL -> DRAIN -> IDLE.
  - IDLE: waits for the hold-load event.
  - SYN: syn_q <= syndrome(hreg) (registered M bits).
  - EVAL: chk_done=1 for exactly this cycle. chk_err <= |syn_q. err_cnt += chk_err, saturating at 2^ERRW-1. Always -> DRAIN.
  - DRAIN: K cycles. Cycle j (j=0..K-1) drives dout=hreg[K-1-j], dout_vld=1. After j=K-1 -> IDLE.
- Latency: bit 0 accepted at cycle t -> chk_done at t+2 -> first dout_vld at t+3 -> last at t+K+2.
- Back-to-back frames: the next fill takes ≥N cycles, which exceeds K+3, so continuous streaming never overflows.
- din_vld low stalls the fill only; the drain is never stalled.
- Reset (any time, including mid-fill or mid-drain):
  - fcnt=0, FSM=IDLE.
  - dout=0, dout_vld=0, chk_done=0, chk_err=0, err_cnt=0, ovf=0.
  - cw, hreg and syn_q need no reset.
  - A partially received frame is discarded.
- Simultaneous frame-complete and last DRAIN cycle: the FSM is not yet IDLE, so the frame is dropped and ovf is set. This is required, not a race.

Optional Feature:
- Macro LDPC_DROP_BAD_EN.
- Defined: in EVAL, a frame with nonzero syndrome goes directly to IDLE with no DRAIN. dout_vld stays 0, while chk_done, chk_err and err_cnt behave as normal.
- Undefined: every frame is drained regardless of chk_err.

Decomposition:
- Package ldpc_802_3an_pkg: N, K, M, ERRW, drain FSM state encoding (IDLE/SYN/EVAL/DRAIN), fill counter width.
- One sub-module, ldpc_syndrome_802_3an_comb: purely combinational, input code_block[N-1:0], output syndrome[M-1:0] = H·c over GF(2).
- The FSM, counters and registers stay in the top.

Test Plan:
- All-zero codeword, din_vld held 1 for 2048 cycles -> chk_done at t+2, chk_err=0, err_cnt=0; 1723 dout_vld cycles, all dout=0.
- Encoder output for info pattern 1723'h1 (only bit 0 set), fed in order -> chk_err=0; dout is 0 for 1722 cycles, then 1 on the final dout_vld cycle.
- Same codeword with bit 2047 flipped -> chk_err=1, err_cnt=1, data still drained. With LDPC_DROP_BAD_EN: no dout_vld.
- Two valid codewords back-to-back, din_vld constant 1 -> two chk_done pulses 2048 cycles apart, ovf=0, no dout_vld gap errors.
- Force a drain conflict by preloading the FSM in DRAIN (din_vld=1 for 2048 cycles starting 100 cycles before the drain ends, via a shortened-K build) -> ovf=1, no second chk_done.
- Assert rst at fcnt=1000, then send a full codeword -> exactly one chk_done, and it reflects only the post-reset frame.
